// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
// Optional header-byte tagging is enabled with the FIFO_WR_ARB_TAG_EN macro.
package fifo_wr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    BURST = 2'd2
  } arb_state_t;

  localparam logic [3:0] HDR_NIBBLE = 4'hA;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// from last+1, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last,
  output logic [IDW-1:0]     grant,
  output logic               any_req
);

  logic [IDW-1:0] cand  [NUM_REQ];
  logic [IDW-1:0] chain [NUM_REQ+1];

  // chain[gi] holds the winner among candidates gi..NUM_REQ-1, so
  // chain[0] favours the candidate closest after last.
  assign chain[NUM_REQ] = last;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    assign cand[gi]  = IDW'((int'(last) + gi + 1) % NUM_REQ);
    assign chain[gi] = req[cand[gi]] ? cand[gi] : chain[gi+1];
  end

  assign grant   = chain[0];
  assign any_req = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ byte
// producers. Define FIFO_WR_ARB_TAG_EN to prefix each burst with a header byte.
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int  NUM_REQ   = 4,
  parameter int  BURST_LEN = 4,
  localparam int IDW       = id_width(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 fifo_full,
  output logic [7:0]           fifo_din,
  output logic                 fifo_wr_en,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy
);

  arb_state_t     state_reg, state_next;
  logic [IDW-1:0] grant_id_reg, grant_next;
  logic [IDW-1:0] last_grant_reg, last_next;
  logic [3:0]     burst_cnt_reg, cnt_next;

  logic [IDW-1:0] pick_idx;
  logic           any_req;
  logic           wr_en_c;
  logic [7:0]     din_c;
  logic           ready_en;
  logic           sel_valid;
  logic [7:0]     sel_byte;
  logic [7:0]     req_bytes [NUM_REQ];

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr_pick (
    .req     (req_valid),
    .last    (last_grant_reg),
    .grant   (pick_idx),
    .any_req (any_req)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
    assign req_bytes[gi] = req_data[8*gi +: 8];
  end

  assign sel_valid = req_valid[grant_id_reg];
  assign sel_byte  = req_bytes[grant_id_reg];

`ifdef FIFO_WR_ARB_TAG_EN
  logic [2:0] gid3;
  assign gid3 = 3'(grant_id_reg);
`endif

  always_comb begin
    state_next = state_reg;
    grant_next = grant_id_reg;
    last_next  = last_grant_reg;
    cnt_next   = burst_cnt_reg;
    wr_en_c    = 1'b0;
    din_c      = 8'h00;
    ready_en   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          grant_next = pick_idx;
          last_next  = pick_idx;
          cnt_next   = 4'd0;
`ifdef FIFO_WR_ARB_TAG_EN
          state_next = HDR;
`else
          state_next = BURST;
`endif
        end
      end
`ifdef FIFO_WR_ARB_TAG_EN
      HDR: begin
        wr_en_c = ~fifo_full;
        din_c   = {HDR_NIBBLE, 1'b0, gid3};
        if (!fifo_full) state_next = BURST;
      end
`endif
      BURST: begin
        ready_en = ~fifo_full;
        wr_en_c  = sel_valid & ~fifo_full;
        din_c    = sel_byte;
        // A stalled but still-valid grantee keeps the grant and its count.
        if (!sel_valid) begin
          state_next = IDLE;
        end else if (!fifo_full) begin
          cnt_next = burst_cnt_reg + 4'd1;
          if (cnt_next == 4'(BURST_LEN)) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_id_reg   <= '0;
      last_grant_reg <= IDW'(NUM_REQ - 1);
      burst_cnt_reg  <= 4'd0;
    end else begin
      state_reg      <= state_next;
      grant_id_reg   <= grant_next;
      last_grant_reg <= last_next;
      burst_cnt_reg  <= cnt_next;
    end
  end

  // Outputs are masked during reset so a byte presented then is never taken.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = ready_en & ~rst & (grant_id_reg == IDW'(gi));
  end

  assign fifo_wr_en = wr_en_c & ~rst;
  assign fifo_din   = fifo_wr_en ? din_c : 8'h00;
  assign grant_id   = grant_id_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (4 requesters, bursts of 4).
// Expectations adapt when FIFO_WR_ARB_TAG_EN is defined.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

`ifdef FIFO_WR_ARB_TAG_EN
  localparam int HDR_CYC = 1;
`else
  localparam int HDR_CYC = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        fifo_full = 1'b0;
  logic [7:0]  fifo_din;
  logic        fifo_wr_en;
  logic [1:0]  grant_id;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int         prod_left [4];
  logic [7:0] prod_next [4];

  logic [7:0] wq_data [$];
  logic [1:0] wq_gid  [$];
  int         wq_cyc  [$];
  logic [7:0] aq_data [$];

  fifo_wr_arbiter #(.NUM_REQ(4), .BURST_LEN(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_din   (fifo_din),
    .fifo_wr_en (fifo_wr_en),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor plus the always-on invariants.
  always @(negedge clk) begin
    if (!rst) begin
      n_cmp++;
      if ($countones(req_ready) > 1) begin
        n_fail++;
        $display("FAIL onehot_ready cyc=%0d got=%b want=at most one bit", cyc, req_ready);
      end
      n_cmp++;
      if (fifo_wr_en && fifo_full) begin
        n_fail++;
        $display("FAIL wr_while_full cyc=%0d got wr_en=1 want wr_en=0", cyc);
      end
      if (fifo_wr_en) begin
        aq_data.push_back(fifo_din);
        if (|req_ready) begin
          wq_data.push_back(fifo_din);
          wq_gid.push_back(grant_id);
          wq_cyc.push_back(cyc);
        end
        $display("[%0d] write din=%02h gid=%0d%s", cyc, fifo_din, grant_id,
                 (|req_ready) ? "" : " header");
      end
    end
  end

  task automatic apply();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]       = (prod_left[i] != 0);
      req_data[8*i +: 8] = prod_next[i];
    end
  endtask

  // One clock; producers advance on bytes accepted at that edge.
  task automatic cycle();
    logic [3:0] xfer;
    @(negedge clk);
    xfer = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (xfer[i]) begin
        prod_left[i]--;
        prod_next[i]++;
      end
    end
    apply();
  endtask

  task automatic do_reset();
    for (int i = 0; i < 4; i++) begin
      prod_left[i] = 0;
      prod_next[i] = 8'h00;
    end
    apply();
    fifo_full = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wq_data.delete();
    wq_gid.delete();
    wq_cyc.delete();
    aq_data.delete();
  endtask

  task automatic test_reset();
    logic [3:0] exp_ready;
    logic [7:0] exp_din;
    for (int i = 0; i < 4; i++) begin
      prod_left[i] = 100;
      prod_next[i] = 8'(8'h01 + i);
    end
    apply();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy, fifo_wr_en, req_ready, fifo_din} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got busy=%b wr=%b rdy=%b din=%02h want all 0",
               busy, fifo_wr_en, req_ready, fifo_din);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, fifo_wr_en, req_ready, fifo_din, grant_id} !== 16'h0) begin
      n_fail++;
      $display("FAIL idle_after_reset got busy=%b wr=%b rdy=%b din=%02h gid=%0d want all 0",
               busy, fifo_wr_en, req_ready, fifo_din, grant_id);
    end
    @(posedge clk);
    #1;
    exp_ready = (HDR_CYC != 0) ? 4'b0000 : 4'b0001;
    exp_din   = (HDR_CYC != 0) ? 8'hA0 : 8'h01;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || grant_id !== 2'd0 || req_ready !== exp_ready
        || fifo_wr_en !== 1'b1 || fifo_din !== exp_din) begin
      n_fail++;
      $display("FAIL first_grant got busy=%b gid=%0d rdy=%b wr=%b din=%02h want 1 0 %b 1 %02h",
               busy, grant_id, req_ready, fifo_wr_en, fifo_din, exp_ready, exp_din);
    end
  endtask

  task automatic test_single_burst();
    do_reset();
    prod_left[0] = 6;
    prod_next[0] = 8'h10;
    apply();
    for (int k = 0; k < 60 && wq_data.size() < 6; k++) cycle();
    n_cmp++;
    if (wq_data.size() != 6) begin
      n_fail++;
      $display("FAIL single_count got=%0d want=6", wq_data.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_cmp++;
        if (wq_data[k] !== 8'(8'h10 + k) || wq_gid[k] !== 2'd0) begin
          n_fail++;
          $display("FAIL single_byte%0d got=%02h/gid%0d want=%02h/gid0",
                   k, wq_data[k], wq_gid[k], 8'(8'h10 + k));
        end
      end
      n_cmp++;
      if (wq_cyc[3] - wq_cyc[0] != 3 || wq_cyc[4] - wq_cyc[3] != 2 + HDR_CYC) begin
        n_fail++;
        $display("FAIL single_timing got span=%0d gap=%0d want span=3 gap=%0d",
                 wq_cyc[3] - wq_cyc[0], wq_cyc[4] - wq_cyc[3], 2 + HDR_CYC);
      end
    end
    repeat (3) cycle();
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || wq_data.size() != 6) begin
      n_fail++;
      $display("FAIL single_release got busy=%b writes=%0d want busy=0 writes=6",
               busy, wq_data.size());
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      prod_left[i] = 8;
      prod_next[i] = 8'(8'h20 + 16 * i);
    end
    apply();
    for (int k = 0; k < 150 && wq_data.size() < 20; k++) cycle();
    for (int i = 0; i < 4; i++) prod_left[i] = 0;
    apply();
    n_cmp++;
    if (wq_data.size() != 20) begin
      n_fail++;
      $display("FAIL rr_count got=%0d want=20", wq_data.size());
    end else begin
      for (int k = 0; k < 20; k++) begin
        int b, r, gap;
        logic [7:0] exp;
        b   = k / 4;
        r   = b % 4;
        exp = 8'(8'h20 + 16 * r + (b / 4) * 4 + k % 4);
        n_cmp++;
        if (wq_data[k] !== exp || wq_gid[k] !== 2'(r)) begin
          n_fail++;
          $display("FAIL rr_byte%0d got=%02h/gid%0d want=%02h/gid%0d",
                   k, wq_data[k], wq_gid[k], exp, r);
        end
        if (k > 0) begin
          gap = (k % 4 == 0) ? 2 + HDR_CYC : 1;
          n_cmp++;
          if (wq_cyc[k] - wq_cyc[k-1] != gap) begin
            n_fail++;
            $display("FAIL rr_gap%0d got=%0d want=%0d", k, wq_cyc[k] - wq_cyc[k-1], gap);
          end
        end
      end
    end
    repeat (3) cycle();
  endtask

  task automatic test_backpressure();
    do_reset();
    prod_left[1] = 4;
    prod_next[1] = 8'h60;
    apply();
    for (int k = 0; k < 40 && wq_data.size() < 2; k++) cycle();
    fifo_full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      n_cmp++;
      if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0 || grant_id !== 2'd1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL full_stall%0d got wr=%b rdy=%b gid=%0d busy=%b want 0 0000 1 1",
                 s, fifo_wr_en, req_ready, grant_id, busy);
      end
      @(posedge clk);
      #1;
    end
    fifo_full = 1'b0;
    for (int k = 0; k < 40 && wq_data.size() < 4; k++) cycle();
    repeat (4) cycle();
    n_cmp++;
    if (wq_data.size() != 4) begin
      n_fail++;
      $display("FAIL full_count got=%0d want=4", wq_data.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (wq_data[k] !== 8'(8'h60 + k) || wq_gid[k] !== 2'd1) begin
          n_fail++;
          $display("FAIL full_byte%0d got=%02h/gid%0d want=%02h/gid1",
                   k, wq_data[k], wq_gid[k], 8'(8'h60 + k));
        end
      end
      n_cmp++;
      if (wq_cyc[2] - wq_cyc[1] != 4 || wq_cyc[3] - wq_cyc[2] != 1) begin
        n_fail++;
        $display("FAIL full_resume got gaps=%0d,%0d want=4,1",
                 wq_cyc[2] - wq_cyc[1], wq_cyc[3] - wq_cyc[2]);
      end
    end
  endtask

  task automatic test_drop_valid();
    logic [7:0] exp_d [4];
    logic [1:0] exp_g [4];
    exp_d = '{8'h70, 8'h80, 8'h81, 8'h82};
    exp_g = '{2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    prod_left[2] = 1;
    prod_next[2] = 8'h70;
    prod_left[3] = 3;
    prod_next[3] = 8'h80;
    apply();
    for (int k = 0; k < 40 && wq_data.size() < 4; k++) cycle();
    n_cmp++;
    if (wq_data.size() != 4) begin
      n_fail++;
      $display("FAIL drop_count got=%0d want=4", wq_data.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (wq_data[k] !== exp_d[k] || wq_gid[k] !== exp_g[k]) begin
          n_fail++;
          $display("FAIL drop_byte%0d got=%02h/gid%0d want=%02h/gid%0d",
                   k, wq_data[k], wq_gid[k], exp_d[k], exp_g[k]);
        end
      end
      n_cmp++;
      if (wq_cyc[1] - wq_cyc[0] != 3 + HDR_CYC) begin
        n_fail++;
        $display("FAIL drop_regrant got gap=%0d want=%0d", wq_cyc[1] - wq_cyc[0], 3 + HDR_CYC);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    prod_left[1] = 8;
    prod_next[1] = 8'h90;
    prod_left[3] = 8;
    prod_next[3] = 8'hB0;
    apply();
    for (int k = 0; k < 40 && wq_data.size() < 2; k++) cycle();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0) begin
      n_fail++;
      $display("FAIL rst_cycle_write got wr=%b rdy=%b want 0 0000", fifo_wr_en, req_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_state got busy=%b gid=%0d want 0 0", busy, grant_id);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 40 && wq_data.size() < 3; k++) cycle();
    n_cmp++;
    if (wq_data.size() != 3) begin
      n_fail++;
      $display("FAIL rst_regrant_count got=%0d want=3", wq_data.size());
    end else begin
      n_cmp++;
      if (wq_gid[0] !== 2'd1 || wq_gid[2] !== 2'd1 || wq_data[2] !== 8'h92) begin
        n_fail++;
        $display("FAIL rst_regrant got first=gid%0d next=%02h/gid%0d want gid1 then 92/gid1",
                 wq_gid[0], wq_data[2], wq_gid[2]);
      end
    end
  endtask

  task automatic test_tag();
    logic [7:0] exp [$];
`ifdef FIFO_WR_ARB_TAG_EN
    exp = '{8'hA3, 8'h55};
`else
    exp = '{8'h55};
`endif
    do_reset();
    prod_left[3] = 1;
    prod_next[3] = 8'h55;
    apply();
    repeat (10) cycle();
    n_cmp++;
    if (aq_data.size() != exp.size()) begin
      n_fail++;
      $display("FAIL tag_count got=%0d want=%0d", aq_data.size(), exp.size());
    end else begin
      for (int k = 0; k < exp.size(); k++) begin
        n_cmp++;
        if (aq_data[k] !== exp[k]) begin
          n_fail++;
          $display("FAIL tag_byte%0d got=%02h want=%02h", k, aq_data[k], exp[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_backpressure();
    test_drop_valid();
    test_reset_mid_burst();
    test_tag();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
